// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low a..g encodings, monitor state and pattern class.
// Segment vectors are ordered {a,b,c,d,e,f,g}; a 0 bit means the segment is lit.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    typedef enum logic [1:0] {CLS_DIGIT, CLS_BLANK, CLS_INVALID} seg_cls_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map of an active-low {a..g} pattern to its class and BCD digit.
// Digit is 0 whenever the class is not CLS_DIGIT.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_cls_t   cls,
    output logic [3:0] digit
);

    always_comb begin
        cls   = CLS_DIGIT;
        digit = 4'd0;
        case (pattern)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: cls   = CLS_BLANK;
            default:   cls   = CLS_INVALID;
        endcase
    end

endmodule

// File: rtl/segment_decoder_7s.sv
// Readback monitor for the active-low 7-segment bus: debounces a pattern, then decodes it.
// Optional SEG7_ERRCNT_EN adds a saturating count of newly accepted invalid patterns.
module segment_decoder_7s
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       dp,
    output logic [3:0] number,
    output logic       valid,
    output logic       blank,
    output logic       invalid,
    output logic       point,
    output logic       update
`ifdef SEG7_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

    state_t               state, state_nxt;
    logic [7:0]           seg_q, cand, cand_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [7:0]           last_acc;
    logic                 have_acc;
    logic                 accept;
    logic                 changed;
    seg_cls_t             cls;
    logic [3:0]           digit;

    seg7_pattern_decode u_decode (
        .pattern (cand[7:1]),
        .cls     (cls),
        .digit   (digit)
    );

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                cand_nxt  = seg_q;
                cnt_nxt   = '0;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (seg_q != cand) begin
                    cand_nxt = seg_q;
                    cnt_nxt  = '0;
                end else if (cnt == CNT_MAX) begin
                    accept    = 1'b1;
                    state_nxt = LOCKED;
                end else begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
            LOCKED: begin
                if (seg_q != cand) begin
                    cand_nxt  = seg_q;
                    cnt_nxt   = '0;
                    state_nxt = SETTLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The first accept after reset always strobes, even if it repeats the pre-reset pattern.
    assign changed = !have_acc || (cand != last_acc);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            seg_q    <= 8'hFF;
            cand     <= 8'hFF;
            cnt      <= '0;
            last_acc <= 8'hFF;
            have_acc <= 1'b0;
            number   <= 4'd0;
            valid    <= 1'b0;
            blank    <= 1'b0;
            invalid  <= 1'b0;
            point    <= 1'b0;
            update   <= 1'b0;
        end else begin
            state  <= state_nxt;
            seg_q  <= {a, b, c, d, e, f, g, dp};
            cand   <= cand_nxt;
            cnt    <= cnt_nxt;
            update <= accept && changed;
            if (accept) begin
                last_acc <= cand;
                have_acc <= 1'b1;
                valid    <= (cls == CLS_DIGIT);
                blank    <= (cls == CLS_BLANK);
                invalid  <= (cls == CLS_INVALID);
                point    <= !cand[0];
                if (cls == CLS_DIGIT) begin
                    number <= digit;
                end
            end
        end
    end

`ifdef SEG7_ERRCNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (accept && changed && (cls == CLS_INVALID) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_segment_decoder_7s.sv
// Scoreboard bench: stimulus queues expected accepts with their cycle, monitors pop on update.
module tb_segment_decoder_7s;
    import seg7_pkg::*;

    typedef struct {
        logic [3:0] number;
        logic       valid;
        logic       blank;
        logic       invalid;
        logic       point;
        int         cyc;
    } exp_t;

    logic       clock;
    logic       reset, reset1;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1;
    logic [3:0] number0, number1;
    logic       valid0, blank0, invalid0, point0, update0;
    logic       valid1, blank1, invalid1, point1, update1;
`ifdef SEG7_ERRCNT_EN
    logic [7:0] err_count0, err_count1;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    segment_decoder_7s #(.STABLE_CYCLES(4), .CNT_WIDTH(4)) u_dut0 (
        .clock   (clock),
        .reset   (reset),
        .a       (seg0[6]),
        .b       (seg0[5]),
        .c       (seg0[4]),
        .d       (seg0[3]),
        .e       (seg0[2]),
        .f       (seg0[1]),
        .g       (seg0[0]),
        .dp      (dp0),
        .number  (number0),
        .valid   (valid0),
        .blank   (blank0),
        .invalid (invalid0),
        .point   (point0),
        .update  (update0)
`ifdef SEG7_ERRCNT_EN
        ,
        .err_count (err_count0)
`endif
    );

    segment_decoder_7s #(.STABLE_CYCLES(1), .CNT_WIDTH(4)) u_dut1 (
        .clock   (clock),
        .reset   (reset1),
        .a       (seg1[6]),
        .b       (seg1[5]),
        .c       (seg1[4]),
        .d       (seg1[3]),
        .e       (seg1[2]),
        .f       (seg1[1]),
        .g       (seg1[0]),
        .dp      (dp1),
        .number  (number1),
        .valid   (valid1),
        .blank   (blank1),
        .invalid (invalid1),
        .point   (point1),
        .update  (update1)
`ifdef SEG7_ERRCNT_EN
        ,
        .err_count (err_count1)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push0(input logic [3:0] num, input logic v, input logic bl,
                         input logic inv, input logic pt, input int lat);
        exp_t x;
        x.number = num; x.valid = v; x.blank = bl; x.invalid = inv; x.point = pt;
        x.cyc = cyc + lat;
        q0.push_back(x);
    endtask

    task automatic push1(input logic [3:0] num, input logic v, input logic bl,
                         input logic inv, input logic pt, input int lat);
        exp_t x;
        x.number = num; x.valid = v; x.blank = bl; x.invalid = inv; x.point = pt;
        x.cyc = cyc + lat;
        q1.push_back(x);
    endtask

    always @(negedge clock) begin
        if (update0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d0_unexpected_update: got update=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("d0_accept_cycle", cyc, e0.cyc);
                chk("d0_number", 32'(number0), 32'(e0.number));
                chk("d0_flags", {28'd0, valid0, blank0, invalid0, point0},
                    {28'd0, e0.valid, e0.blank, e0.invalid, e0.point});
            end
        end
        if (update1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d1_unexpected_update: got update=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("d1_accept_cycle", cyc, e1.cyc);
                chk("d1_number", 32'(number1), 32'(e1.number));
                chk("d1_flags", {28'd0, valid1, blank1, invalid1, point1},
                    {28'd0, e1.valid, e1.blank, e1.invalid, e1.point});
            end
        end
    end

    initial begin
        logic [6:0] inv_a, inv_b;
        inv_a  = 7'b1111110;
        inv_b  = 7'b1111101;
        reset  = 1'b1;
        reset1 = 1'b1;
        seg0   = SEG_BLANK;
        dp0    = 1'b1;
        seg1   = SEG_BLANK;
        dp1    = 1'b1;
        tick(3);
        chk("rst_number", 32'(number0), 32'd0);
        chk("rst_flags", {27'd0, valid0, blank0, invalid0, point0, update0}, 32'd0);

        // Digit 3 with dp dark, accepted six edges after release.
        reset = 1'b0;
        seg0  = SEG_3;
        dp0   = 1'b1;
        push0(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        tick(12);
        chk("hold3_update_low", 32'(update0), 32'd0);
        chk("hold3_number", 32'(number0), 32'd3);

        // Two-sample glitch inside a locked 5 must not disturb the outputs.
        seg0 = SEG_5;
        push0(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        tick(10);
        seg0 = SEG_8;
        tick(2);
        seg0 = SEG_5;
        tick(12);
        chk("glitch_number", 32'(number0), 32'd5);
        chk("glitch_valid", 32'(valid0), 32'd1);

        seg0 = SEG_7;
        push0(4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        tick(10);
        seg0 = SEG_8;
        dp0  = 1'b0;
        push0(4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 6);
        tick(10);

        // Blank and invalid keep the last digit.
        seg0 = SEG_BLANK;
        dp0  = 1'b1;
        push0(4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 6);
        tick(10);
        seg0 = inv_a;
        push0(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 6);
        tick(10);
`ifdef SEG7_ERRCNT_EN
        chk("errcnt_one", 32'(err_count0), 32'd1);
`endif

        // Reset while settling with cnt=2.
        seg0 = SEG_0;
        tick(4);
        chk("pre_rst_cnt", 32'(u_dut0.cnt), 32'd2);
        reset = 1'b1;
        tick(1);
        chk("midrst_number", 32'(number0), 32'd0);
        chk("midrst_flags", {27'd0, valid0, blank0, invalid0, point0, update0}, 32'd0);
        chk("midrst_state", 32'(u_dut0.state), 32'(IDLE));
        reset = 1'b0;
        push0(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        tick(10);
`ifdef SEG7_ERRCNT_EN
        chk("errcnt_after_rst", 32'(err_count0), 32'd0);
`endif

        // STABLE_CYCLES=1 instance: each change accepted three edges later.
        reset1 = 1'b0;
        seg1   = SEG_1;
        push1(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        tick(3);
        for (int i = 0; i < 6; i++) begin
            seg1 = (i % 2 == 0) ? SEG_2 : SEG_1;
            push1((i % 2 == 0) ? 4'd2 : 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
            tick(3);
        end
        chk("fast_number", 32'(number1), 32'd1);
`ifdef SEG7_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            seg1 = (i % 2 == 0) ? inv_a : inv_b;
            push1(4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3);
            tick(3);
        end
        chk("errcnt_saturate", 32'(err_count1), 32'd255);
`endif

        tick(5);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
